// File: rtl/activation_requant_if.sv
// Valid/ready bundle between the pre-activation stage, the requantizer and the
// next layer. The master drives beats in and accepts results; the slave is the requantizer.
interface activation_requant_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 18,
  parameter int SHIFT_WIDTH = 5
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [ACC_WIDTH-1:0]   pre;
  logic        [1:0]             act_sel;
  logic        [SHIFT_WIDTH-1:0] shift;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DATA_WIDTH-1:0]  act_out;

  modport master (
    output in_valid, pre, act_sel, shift, out_ready,
    input  in_ready, out_valid, act_out
  );

  modport slave (
    input  in_valid, pre, act_sel, shift, out_ready,
    output in_ready, out_valid, act_out
  );
endinterface

// File: rtl/activation_requant.sv
// Applies identity/ReLU/leaky ReLU to a signed pre-activation, then rounds, shifts
// and saturates it to DATA_WIDTH through a two-stage valid/ready pipeline.
module activation_requant #(
  parameter int DATA_WIDTH  = 8,
  parameter int N           = 4,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH + $clog2(N),
  parameter int SHIFT_WIDTH = 5,
  parameter int LEAKY_SHIFT = 3,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  activation_requant_if.slave  bus,
  output logic                 sat_flag,
  input  logic                 sat_clr,
  output logic [CNT_WIDTH-1:0] sat_count
);
  localparam logic [1:0] SEL_RELU  = 2'd1;
  localparam logic [1:0] SEL_LEAKY = 2'd2;
  localparam logic [SHIFT_WIDTH:0]   SHIFT_LIMIT = (SHIFT_WIDTH+1)'(ACC_WIDTH);
  localparam logic [SHIFT_WIDTH-1:0] SHIFT_ONE   = {{(SHIFT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] ONE_EXT  = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH:0] SAT_MAX  = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN  = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                          s1_valid_r;
  logic signed [ACC_WIDTH-1:0]   s1_pre_r;
  logic        [1:0]             s1_sel_r;
  logic        [SHIFT_WIDTH-1:0] s1_shift_r;
  logic                          out_valid_r;
  logic signed [DATA_WIDTH-1:0]  act_out_r;
  logic                          sat_flag_r;
  logic        [CNT_WIDTH-1:0]   sat_count_r;

  logic                          s2_load_s;
  logic                          in_ready_s;
  logic                          accept_s;
  logic signed [ACC_WIDTH-1:0]   act_s;
  logic signed [ACC_WIDTH:0]     rnd_s;
  logic signed [ACC_WIDTH:0]     sum_s;
  logic signed [ACC_WIDTH:0]     r_s;
  logic signed [DATA_WIDTH-1:0]  clamp_s;
  logic                          sat_s;

  assign s2_load_s  = s1_valid_r && (!out_valid_r || bus.out_ready);
  assign in_ready_s = !rst && (!s1_valid_r || s2_load_s);
  assign accept_s   = bus.in_valid && in_ready_s;

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.act_out   = act_out_r;
  assign sat_flag      = sat_flag_r;
  assign sat_count     = sat_count_r;

  // Activation function on the stage-1 beat using its own captured select.
  always_comb begin
    act_s = s1_pre_r;
    case (s1_sel_r)
      SEL_RELU: begin
        if (s1_pre_r[ACC_WIDTH-1]) act_s = '0;
        else                       act_s = s1_pre_r;
      end
      SEL_LEAKY: begin
        if (s1_pre_r[ACC_WIDTH-1]) act_s = s1_pre_r >>> LEAKY_SHIFT;
        else                       act_s = s1_pre_r;
      end
      default: act_s = s1_pre_r;
    endcase
  end

  // Round-half-up shift at ACC_WIDTH+1 bits; out-of-range shifts collapse to the sign.
  always_comb begin
    rnd_s = '0;
    sum_s = '0;
    r_s   = '0;
    if ({1'b0, s1_shift_r} >= SHIFT_LIMIT) begin
      if (act_s[ACC_WIDTH-1]) r_s = '1;
      else                    r_s = '0;
    end else begin
      if (s1_shift_r != '0) rnd_s = ONE_EXT << (s1_shift_r - SHIFT_ONE);
      else                  rnd_s = '0;
      sum_s = {act_s[ACC_WIDTH-1], act_s} + rnd_s;
      r_s   = sum_s >>> s1_shift_r;
    end
  end

  // Saturate the shifted value to the signed output range.
  always_comb begin
    if (r_s > SAT_MAX) begin
      clamp_s = SAT_MAX[DATA_WIDTH-1:0];
      sat_s   = 1'b1;
    end else if (r_s < SAT_MIN) begin
      clamp_s = SAT_MIN[DATA_WIDTH-1:0];
      sat_s   = 1'b1;
    end else begin
      clamp_s = r_s[DATA_WIDTH-1:0];
      sat_s   = 1'b0;
    end
  end

  // Stage 1: capture the beat together with its configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_pre_r   <= '0;
      s1_sel_r   <= 2'd0;
      s1_shift_r <= '0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_pre_r   <= bus.pre;
      s1_sel_r   <= bus.act_sel;
      s1_shift_r <= bus.shift;
    end else if (s2_load_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Stage 2: output register, held stable while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      act_out_r   <= '0;
    end else if (s2_load_s) begin
      out_valid_r <= 1'b1;
      act_out_r   <= clamp_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturation bookkeeping, once per beat at its stage-2 load; a saturating load wins over clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag_r  <= 1'b0;
      sat_count_r <= '0;
    end else if (s2_load_s && sat_s) begin
      sat_flag_r <= 1'b1;
      if (sat_clr)                 sat_count_r <= CNT_ONE;
      else if (sat_count_r != '1)  sat_count_r <= sat_count_r + CNT_ONE;
      else                         sat_count_r <= sat_count_r;
    end else if (sat_clr) begin
      sat_flag_r  <= 1'b0;
      sat_count_r <= '0;
    end else begin
      sat_flag_r  <= sat_flag_r;
      sat_count_r <= sat_count_r;
    end
  end
endmodule
